// File: rtl/ptp_pkg.sv
// Shared constants, ToD field layout and helpers for the PTP hardware clock.
package ptp_pkg;

  localparam logic [29:0]        NS_PER_S   = 30'd1_000_000_000;
  localparam logic signed [30:0] STEP_LIMIT = 31'sd999_999_999;

  // 96-bit ToD layout: {seconds[47:0], 2'b00, ns[29:0], fns[15:0]}
  localparam int TOD_FNS_LSB = 0;
  localparam int TOD_NS_LSB  = 16;
  localparam int TOD_S_LSB   = 48;

  typedef enum logic {
    STEP_IDLE,
    STEP_CALC
  } step_state_t;

  // Left-justify a width-bit fractional-ns value into the 16-bit output field.
  function automatic logic [15:0] fns_to_16(input logic [31:0] fns, input int unsigned width);
    logic [31:0] just;
    just = fns << (32 - width);
    return just[31:16];
  endfunction

endpackage

// File: rtl/ptp_capture_ch.sv
// One event-timestamp channel: rising-edge detect, ToD latch and one-cycle strobe.
module ptp_capture_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic        capt_in,
  input  logic [95:0] ts_96,
  output logic [95:0] capt_ts,
  output logic        capt_valid
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 1'b0;
      capt_ts    <= '0;
      capt_valid <= 1'b0;
    end else begin
      prev       <= capt_in;
      capt_valid <= capt_in && !prev;
      if (capt_in && !prev) capt_ts <= ts_96;
    end
  end

endmodule

// File: rtl/ptp_clock_ext.sv
// PTP hardware clock: 96-bit ToD and 64-bit ns counter with slew, atomic steps,
// event capture and stretched PPS.
module ptp_clock_ext
  import ptp_pkg::*;
#(
  parameter int                         FNS_WIDTH       = 16,
  parameter int                         PERIOD_NS_WIDTH = 4,
  parameter logic [PERIOD_NS_WIDTH-1:0] PERIOD_NS       = 'h6,
  parameter logic [FNS_WIDTH-1:0]       PERIOD_FNS      = 'h6666,
  parameter int                         ADJ_NS_WIDTH    = 4,
  parameter int                         NUM_CAPT        = 2,
  parameter logic [15:0]                PPS_STRETCH     = 16'd125,
  parameter int                         PIPELINE_OUTPUT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [95:0]                  set_ts_96,
  input  logic                         set_valid,
  input  logic [PERIOD_NS_WIDTH-1:0]   period_ns,
  input  logic [FNS_WIDTH-1:0]         period_fns,
  input  logic                         period_valid,
  input  logic [ADJ_NS_WIDTH-1:0]      adj_ns,
  input  logic [FNS_WIDTH-1:0]         adj_fns,
  input  logic [15:0]                  adj_count,
  input  logic                         adj_valid,
  output logic                         adj_active,
  input  logic signed [30:0]           step_ns,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [NUM_CAPT-1:0]          capt_in,
  output logic [96*NUM_CAPT-1:0]       capt_ts,
  output logic [NUM_CAPT-1:0]          capt_valid,
  output logic [95:0]                  ts_96,
  output logic [63:0]                  ts_64,
  output logic                         ts_step,
  output logic                         pps,
  output logic                         pps_str
);

  localparam int INC_W = FNS_WIDTH + 32;
  localparam int T64_W = FNS_WIDTH + 48;
  localparam int ADJ_W = ADJ_NS_WIDTH + FNS_WIDTH;
  localparam int OUT_W = 96 + 64 + 3;

  logic [47:0]                          sec_q;
  logic [29:0]                          ns_q;
  logic [FNS_WIDTH-1:0]                 fns_q;
  logic [T64_W-1:0]                     cnt64_q;
  logic [PERIOD_NS_WIDTH+FNS_WIDTH-1:0] period_q;
  logic signed [ADJ_W-1:0]              adj_q;
  logic [15:0]                          adj_cnt_q;
  step_state_t                          state_q, state_d;
  logic signed [30:0]                   step_q;
  logic                                 ready_q, pps_q, ts_step_q;
  logic [15:0]                          pps_cnt_q;

  logic signed [INC_W-1:0] inc;
  logic [FNS_WIDTH:0]      fns_sum;
  logic signed [33:0]      ns_sum;
  logic                    accept, commit, wrap_up, wrap_dn, pps_d;
  logic [47:0]             sec_d;
  logic [29:0]             ns_d;
  logic signed [30:0]      step_clamped;
  logic [T64_W-1:0]        step64;
  logic [31:0]             set_just;
  logic [FNS_WIDTH-1:0]    set_fns;

  assign adj_active = (adj_cnt_q != '0);
  assign step_ready = ready_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      STEP_IDLE: if (step_valid) begin
        accept  = 1'b1;
        state_d = STEP_CALC;
      end
      STEP_CALC: begin
        commit  = !set_valid;  // a concurrent ToD load discards the step
        state_d = STEP_IDLE;
      end
      default: state_d = STEP_IDLE;
    endcase
  end

  always_comb begin
    step_clamped = step_ns;
    if (step_ns > STEP_LIMIT)       step_clamped = STEP_LIMIT;
    else if (step_ns < -STEP_LIMIT) step_clamped = -STEP_LIMIT;
  end

  always_comb begin
    inc = $signed(INC_W'(period_q));
    if (adj_active) inc = inc + INC_W'(adj_q);
    step64 = commit ? (T64_W'(step_q) << FNS_WIDTH) : '0;

    fns_sum = {1'b0, fns_q} + {1'b0, inc[FNS_WIDTH-1:0]};
    ns_sum  = $signed({4'b0, ns_q}) + $signed({2'b0, inc[INC_W-1:FNS_WIDTH]})
            + $signed({33'b0, fns_sum[FNS_WIDTH]});
    if (commit) ns_sum = ns_sum + 34'(step_q);

    wrap_up = ns_sum >= $signed({4'b0, NS_PER_S});
    wrap_dn = ns_sum < 0;
    sec_d   = sec_q;
    ns_d    = ns_sum[29:0];
    if (wrap_up) begin
      sec_d = sec_q + 48'd1;
      ns_d  = 30'(ns_sum - $signed({4'b0, NS_PER_S}));
    end else if (wrap_dn) begin
      sec_d = sec_q - 48'd1;
      ns_d  = 30'(ns_sum + $signed({4'b0, NS_PER_S}));
    end
    pps_d = wrap_up && !commit && !set_valid;

    set_just = {set_ts_96[TOD_NS_LSB-1:TOD_FNS_LSB], 16'b0};
    set_fns  = set_just[31 -: FNS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q     <= '0;
      ns_q      <= '0;
      fns_q     <= '0;
      cnt64_q   <= '0;
      period_q  <= {PERIOD_NS, PERIOD_FNS};
      adj_q     <= '0;
      adj_cnt_q <= '0;
      state_q   <= STEP_IDLE;
      step_q    <= '0;
      ready_q   <= 1'b1;
      pps_q     <= 1'b0;
      ts_step_q <= 1'b0;
      pps_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == STEP_IDLE);
      if (accept)       step_q   <= step_clamped;
      if (period_valid) period_q <= {period_ns, period_fns};
      if (adj_valid) begin
        adj_q     <= $signed({adj_ns, adj_fns});
        adj_cnt_q <= adj_count;
      end else if (adj_active) begin
        adj_cnt_q <= adj_cnt_q - 16'd1;
      end

      cnt64_q <= cnt64_q + T64_W'(inc) + step64;
      if (set_valid) begin
        sec_q <= set_ts_96[95:TOD_S_LSB];
        ns_q  <= set_ts_96[TOD_NS_LSB+29:TOD_NS_LSB];
        fns_q <= set_fns;
      end else begin
        sec_q <= sec_d;
        ns_q  <= ns_d;
        fns_q <= fns_sum[FNS_WIDTH-1:0];
      end

      pps_q     <= pps_d;
      ts_step_q <= set_valid || commit || adj_active;
      if (pps_d)                 pps_cnt_q <= PPS_STRETCH;
      else if (pps_cnt_q != '0)  pps_cnt_q <= pps_cnt_q - 16'd1;
    end
  end

  logic [OUT_W-1:0] out_raw, out_pipe;
  assign out_raw = {sec_q, 2'b00, ns_q, fns_to_16(32'(fns_q), FNS_WIDTH),
                    cnt64_q[T64_W-1:FNS_WIDTH],
                    fns_to_16(32'(cnt64_q[FNS_WIDTH-1:0]), FNS_WIDTH),
                    pps_q, (pps_cnt_q != '0), ts_step_q};

  if (PIPELINE_OUTPUT == 0) begin : g_no_pipe
    assign out_pipe = out_raw;
  end else begin : g_pipe
    logic [PIPELINE_OUTPUT-1:0][OUT_W-1:0] stage_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= out_raw;
        for (int i = 1; i < PIPELINE_OUTPUT; i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign out_pipe = stage_q[PIPELINE_OUTPUT-1];
  end

  assign {ts_96, ts_64, pps, pps_str, ts_step} = out_pipe;

  for (genvar i = 0; i < NUM_CAPT; i++) begin : g_capt
    ptp_capture_ch u_ch (
      .clk        (clk),
      .rst        (rst),
      .capt_in    (capt_in[i]),
      .ts_96      (ts_96),
      .capt_ts    (capt_ts[96*i +: 96]),
      .capt_valid (capt_valid[i])
    );
  end

endmodule

// File: tb/tb_ptp_clock_ext.sv
// Self-checking bench for ptp_clock_ext: whole-time behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ptp_clock_ext;

  logic               clk = 1'b0;
  logic               rst;
  logic [95:0]        set_ts_96;
  logic               set_valid;
  logic [3:0]         period_ns;
  logic [15:0]        period_fns;
  logic               period_valid;
  logic [3:0]         adj_ns;
  logic [15:0]        adj_fns;
  logic [15:0]        adj_count;
  logic               adj_valid;
  logic               adj_active;
  logic signed [30:0] step_ns;
  logic               step_valid;
  logic               step_ready;
  logic [1:0]         capt_in;
  logic [191:0]       capt_ts;
  logic [1:0]         capt_valid;
  logic [95:0]        ts_96;
  logic [63:0]        ts_64;
  logic               ts_step, pps, pps_str;

  ptp_clock_ext dut (
    .clk(clk), .rst(rst),
    .set_ts_96(set_ts_96), .set_valid(set_valid),
    .period_ns(period_ns), .period_fns(period_fns), .period_valid(period_valid),
    .adj_ns(adj_ns), .adj_fns(adj_fns), .adj_count(adj_count), .adj_valid(adj_valid),
    .adj_active(adj_active),
    .step_ns(step_ns), .step_valid(step_valid), .step_ready(step_ready),
    .capt_in(capt_in), .capt_ts(capt_ts), .capt_valid(capt_valid),
    .ts_96(ts_96), .ts_64(ts_64), .ts_step(ts_step), .pps(pps), .pps_str(pps_str)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time kept as seconds plus a single fixed-point ns value (16 fractional bits).
  localparam longint ONE_S  = 64'd1_000_000_000 * 64'd65536;
  localparam longint MASK48 = 64'hFFFF_FFFF_FFFF;
  longint      m_s, m_nf, m_period, m_adj, m_step;
  logic [63:0] m_t64;
  int          m_adj_cnt, m_pps_cnt;
  bit          m_pend, m_ready, m_pps, m_ts_step;
  bit          m_prev [2];
  bit          m_capt_v [2];
  logic [95:0] m_capt_ts [2];

  function automatic logic [95:0] m_ts96();
    logic [63:0] s;
    s = 64'(m_s);
    return {s[47:0], 2'b00, 30'(m_nf >>> 16), 16'(m_nf)};
  endfunction

  task automatic model_reset();
    m_s = 0; m_nf = 0; m_t64 = '0; m_period = 64'h6_6666; m_adj = 0; m_step = 0;
    m_adj_cnt = 0; m_pps_cnt = 0; m_pend = 0; m_ready = 1; m_pps = 0; m_ts_step = 0;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 0; m_capt_v[i] = 0; m_capt_ts[i] = '0;
    end
  endtask

  task automatic model_update();
    longint             inc, stp;
    bit                 commit;
    logic [95:0]        cur;
    logic signed [19:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    cur    = m_ts96();
    inc    = m_period + ((m_adj_cnt > 0) ? m_adj : 64'sd0);
    commit = m_pend && !set_valid;
    stp    = commit ? m_step * 65536 : 0;
    for (int i = 0; i < 2; i++) begin
      m_capt_v[i] = capt_in[i] && !m_prev[i];
      if (m_capt_v[i]) m_capt_ts[i] = cur;
      m_prev[i] = capt_in[i];
    end
    m_t64 = m_t64 + 64'(inc + stp);
    m_pps = 0;
    if (set_valid) begin
      m_s  = longint'(set_ts_96[95:48]);
      m_nf = longint'({set_ts_96[45:16], set_ts_96[15:0]});
    end else begin
      m_nf = m_nf + inc + stp;
      if (m_nf >= ONE_S) begin
        m_nf -= ONE_S; m_s = (m_s + 1) & MASK48; m_pps = !commit;
      end else if (m_nf < 0) begin
        m_nf += ONE_S; m_s = (m_s - 1) & MASK48;
      end
    end
    m_ts_step = set_valid || commit || (m_adj_cnt > 0);
    if (adj_valid) begin
      a = {adj_ns, adj_fns};
      m_adj = longint'(a);
      m_adj_cnt = int'(adj_count);
    end else if (m_adj_cnt > 0) m_adj_cnt--;
    if (period_valid) m_period = longint'({period_ns, period_fns});
    if (m_pend) begin
      m_pend = 0; m_ready = 1;
    end else if (step_valid) begin
      m_pend = 1; m_ready = 0;
      m_step = longint'(step_ns);
      if (m_step > 999_999_999) m_step = 999_999_999;
      if (m_step < -999_999_999) m_step = -999_999_999;
    end
    if (m_pps) m_pps_cnt = 125;
    else if (m_pps_cnt > 0) m_pps_cnt--;
  endtask

  task automatic compare();
    check("ts_96", ts_96, m_ts96());
    check("ts_64", ts_64, m_t64);
    check("pps", pps, m_pps);
    check("pps_str", pps_str, m_pps_cnt > 0);
    check("ts_step", ts_step, m_ts_step);
    check("step_ready", step_ready, m_ready);
    check("adj_active", adj_active, m_adj_cnt > 0);
    for (int i = 0; i < 2; i++) begin
      check("capt_valid", capt_valid[i], m_capt_v[i]);
      check("capt_ts", capt_ts[96*i +: 96], m_capt_ts[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    set_valid = 0; period_valid = 0; adj_valid = 0; step_valid = 0; capt_in = '0;
  endtask

  function automatic logic [95:0] tod(input logic [47:0] s, input logic [29:0] ns,
                                      input logic [15:0] f);
    return {s, 2'b00, ns, f};
  endfunction

  logic [95:0] saved, saved2, set_val;
  logic [63:0] t0;
  int          cnt_a, cnt_b;

  initial begin
    model_reset();
    rst = 1; set_ts_96 = '0; period_ns = 4'h6; period_fns = 16'h6666;
    adj_ns = '0; adj_fns = '0; adj_count = '0; step_ns = '0;
    idle_inputs();
    repeat (3) cycle();
    check("reset ts_96", ts_96, 96'd0);
    check("reset step_ready", step_ready, 1'b1);
    rst = 0;

    // Nominal 6.4 ns period: 10000 cycles -> ~64000 ns, seconds stay 0
    repeat (10000) cycle();
    check("nominal ns range", (ts_64[63:16] >= 63990 && ts_64[63:16] <= 64010), 1'b1);
    check("nominal s", ts_96[95:48], 48'd0);

    // Second rollover from s=5, ns=999,999,990
    set_ts_96 = tod(48'd5, 30'd999_999_990, 16'h0); set_valid = 1;
    cycle();
    check("set load", ts_96, tod(48'd5, 30'd999_999_990, 16'h0));
    check("set ts_step", ts_step, 1'b1);
    set_valid = 0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (i == 1) begin
        check("rollover s", ts_96[95:48], 48'd6);
        check("rollover ns", ts_96[45:16], 30'd2);
      end
      cnt_a += int'(pps);
      cnt_b += int'(pps_str);
    end
    check("pps count", cnt_a, 1);
    check("pps_str count", cnt_b, 125);

    // Step -500 committed while ns=200 -> borrow into seconds
    set_ts_96 = tod(48'd10, 30'd200, 16'h0); set_valid = 1;
    step_ns = -31'sd500; step_valid = 1;
    cycle();
    check("step ready low", step_ready, 1'b0);
    set_valid = 0; step_valid = 0;
    cycle();
    check("step borrow s", ts_96[95:48], 48'd9);
    check("step borrow ns", ts_96[45:16], 30'd999_999_706);
    check("step ts_step", ts_step, 1'b1);
    check("step ready high", step_ready, 1'b1);

    // Oversized positive step clamps to 999,999,999
    set_ts_96 = tod(48'd20, 30'd500_000_000, 16'h0); set_valid = 1;
    step_ns = 31'sh3FFF_FFFF; step_valid = 1;
    cycle();
    set_valid = 0; step_valid = 0;
    cycle();
    check("clamp s", ts_96[95:48], 48'd21);
    check("clamp ns", ts_96[45:16], 30'd500_000_005);

    // Slew +1 ns for 10 cycles
    cycle();
    t0 = ts_64;
    adj_ns = 4'd1; adj_fns = 16'h0; adj_count = 16'd10; adj_valid = 1;
    cycle();
    cnt_a = int'(adj_active);
    adj_valid = 0;
    repeat (20) begin
      cycle();
      cnt_a += int'(adj_active);
    end
    check("slew delta", ts_64 - t0, 64'd9_463_390);
    check("adj_active cycles", cnt_a, 10);

    // Simultaneous capture on both channels, then an overwrite on channel 0
    saved = ts_96; capt_in = 2'b11;
    cycle();
    check("capt both valid", capt_valid, 2'b11);
    check("capt ch0", capt_ts[95:0], saved);
    check("capt ch1", capt_ts[191:96], saved);
    capt_in = 2'b00;
    cycle();
    saved2 = ts_96; capt_in = 2'b01;
    cycle();
    check("recapt valid", capt_valid, 2'b01);
    check("recapt ch0", capt_ts[95:0], saved2);
    check("recapt ch1 kept", capt_ts[191:96], saved);
    capt_in = 2'b00;

    // ToD load during CALC discards the step
    step_ns = 31'sd1000; step_valid = 1;
    cycle();
    step_valid = 0;
    set_val = tod(48'd77, 30'd123_456_789, 16'h8000);
    set_ts_96 = set_val; set_valid = 1;
    cycle();
    check("abort set wins", ts_96, set_val);
    check("abort ready", step_ready, 1'b1);
    set_valid = 0;
    cycle();
    check("abort no step", ts_96, tod(48'd77, 30'd123_456_795, 16'hE666));

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      capt_in = 2'($urandom);
      if ($urandom_range(0, 99) < 3) begin
        set_valid = 1;
        set_ts_96 = tod(48'({$urandom, $urandom}),
                        ($urandom_range(0, 1) == 1) ? 30'($urandom_range(999_999_900, 999_999_999))
                                                    : 30'($urandom_range(0, 999_999_999)),
                        16'($urandom));
      end
      if ($urandom_range(0, 99) < 10) begin
        step_valid = 1; step_ns = 31'($urandom);
      end
      if ($urandom_range(0, 99) < 3) begin
        period_valid = 1;
        period_ns = 4'($urandom_range(4, 9)); period_fns = 16'($urandom);
      end
      if ($urandom_range(0, 99) < 3) begin
        adj_valid = 1;
        adj_ns = 4'($urandom_range(0, 4) + 14);  // -2..+2 in 4-bit two's complement
        adj_fns = 16'($urandom); adj_count = 16'($urandom_range(0, 20));
      end
      if (i == 2000) begin
        step_valid = 1; step_ns = 31'sd12345;
        cycle();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        check("reset mid-step ts", ts_96, 96'd0);
        check("reset mid-step ready", step_ready, 1'b1);
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
